// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
//   Iterative RV32M multiply/divide sequencer. Operands and funct3 are latched
//   when start is seen in IDLE. A radix-2 shift-add multiply or a restoring
//   divide then runs on operand magnitudes, one bit per cycle. The sign is
//   applied once, when the result register is written on entry to DONE.
//   Divide-by-zero and signed overflow are resolved at accept and skip RUN.
//
// Ports
//   clk     in   1     core clock
//   reset   in   1     asynchronous, active-high
//   start   in   1     M-extension instruction in execute (held while stall=1)
//   op      in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,
//                              4 DIV,5 DIVU,6 REM,7 REMU
//   rs1     in   XLEN  operand A (multiplicand / dividend)
//   rs2     in   XLEN  operand B (multiplier / divisor)
//   stall   out  1     freeze PC/pipeline this cycle
//   busy    out  1     state != IDLE
//   done    out  1     one-cycle pulse, result valid
//   result  out  XLEN  final value, held until the next DONE
//
// States
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; operands latched and special cases decoded
//   RUN    | one multiply/divide iteration per cycle, XLEN iterations
//   DONE   | done pulse; result register was written on entry
// ---------------------------------------------------------------------------
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [2:0]          op_q,     op_d;
    logic                neg_q,    neg_d;
    logic [XLEN-1:0]     opnd_q,   opnd_d;
    logic [2*XLEN-1:0]   acc_q,    acc_d;
    logic [XLEN-1:0]     rem_q,    rem_d;
    logic [CW-1:0]       count_q,  count_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Operand decode at accept time
    logic            a_signed, b_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_by_zero, div_ovf;

    // Iteration datapath
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;
    logic [XLEN-1:0]   quo_next;
    logic [XLEN-1:0]   rem_next;
    logic [2*XLEN-1:0] div_next;

    // Final result shaping
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo_signed;
    logic [XLEN-1:0]   rem_signed;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        a_signed    = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        b_signed    = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        a_neg       = a_signed && rs1[XLEN-1];
        b_neg       = b_signed && rs2[XLEN-1];
        a_mag       = a_neg ? (~rs1 + 1'b1) : rs1;
        b_mag       = b_neg ? (~rs2 + 1'b1) : rs2;
        div_by_zero = op[2] && (rs2 == '0);
        // Only DIV/REM (op[0]==0) are signed divides
        div_ovf     = op[2] && !op[0] && (rs1 == INT_MIN) && (rs2 == '1);
    end

    always_comb begin
        // Multiply: acc = {partial_hi, multiplier}; add multiplicand into the
        // high half when the current multiplier bit is set, then shift right.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Restoring divide: acc[XLEN-1:0] holds the dividend shifting out MSB
        // first while quotient bits shift in at the bottom. The partial
        // remainder stays below the divisor, so XLEN+1 bits hold the trial.
        div_shift = {rem_q, acc_q[XLEN-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        if (!div_trial[XLEN]) begin
            rem_next = div_trial[XLEN-1:0];
            quo_next = {acc_q[XLEN-2:0], 1'b1};
        end else begin
            rem_next = div_shift[XLEN-1:0];
            quo_next = {acc_q[XLEN-2:0], 1'b0};
        end
        div_next = {acc_q[2*XLEN-1:XLEN], quo_next};

        // Result is formed from the last iteration's next-state values so the
        // result register is written on the same edge that enters DONE.
        prod_signed = neg_q ? (~mul_next + 1'b1) : mul_next;
        quo_signed  = neg_q ? (~quo_next + 1'b1) : quo_next;
        rem_signed  = neg_q ? (~rem_next + 1'b1) : rem_next;

        case (op_q)
            3'd0:          final_res = prod_signed[XLEN-1:0];
            3'd1,
            3'd2,
            3'd3:          final_res = prod_signed[2*XLEN-1:XLEN];
            3'd4,
            3'd5:          final_res = quo_signed;
            default:       final_res = rem_signed;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        count_d  = count_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    // REM takes the dividend's sign; everything else the XOR
                    neg_d   = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
                    count_d = '0;
                    if (div_by_zero) begin
                        result_d = op[1] ? rs1 : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = op[1] ? '0 : rs1;
                        state_d  = S_DONE;
                    end else begin
                        // opnd holds whichever magnitude is added/subtracted
                        // each iteration; acc holds the one shifted through.
                        opnd_d  = op[2] ? b_mag : a_mag;
                        acc_d   = {{XLEN{1'b0}}, (op[2] ? a_mag : b_mag)};
                        rem_d   = '0;
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                acc_d   = op_q[2] ? div_next : mul_next;
                rem_d   = op_q[2] ? rem_next : rem_q;
                count_d = count_q + CW'(1);
                if (count_q == CW'(XLEN-1)) begin
                    result_d = final_res;
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    assign stall  = ((state_q == S_IDLE) && start) || (state_q == S_RUN);
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq
//   Directed bench for muldiv_seq (XLEN=32). Inputs change 1 ns after the
//   rising edge and outputs are sampled there, so "cycle N" is the interval
//   following the Nth rising edge after the accept cycle (cycle 0).
// ---------------------------------------------------------------------------
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        int          lat;
    } vec_t;

    muldiv_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one op in the current (IDLE) cycle, holds start until done,
    // then drops start for one cycle. Returns observations only.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res,
                         output int lat, output int stall_gaps,
                         output logic extra_done, output logic timed_out);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        lat = 0; stall_gaps = 0; timed_out = 1'b1; res = 32'd0;
        #1;
        if (stall !== 1'b1) stall_gaps++;
        for (int i = 1; i <= 40; i++) begin
            tick;
            lat = i;
            if (done === 1'b1) begin
                res = result;
                timed_out = 1'b0;
                break;
            end
            if (stall !== 1'b1) stall_gaps++;
        end
        start = 1'b0;
        tick;
        extra_done = done;
    endtask

    task automatic run_table(input string tag, input vec_t v[]);
        logic [31:0] res;
        int          lat, gaps;
        logic        xd, to;
        foreach (v[i]) begin
            do_op(v[i].o, v[i].a, v[i].b, res, lat, gaps, xd, to);
            n_checks++;
            if (to !== 1'b0) begin
                n_fail++;
                $display("FAIL %s[%0d] timeout: no done within 40 cycles", tag, i);
            end
            n_checks++;
            if (res !== v[i].e) begin
                n_fail++;
                $display("FAIL %s[%0d] result: got %h expected %h", tag, i, res, v[i].e);
            end
            n_checks++;
            if (lat != v[i].lat) begin
                n_fail++;
                $display("FAIL %s[%0d] latency: got %0d expected %0d", tag, i, lat, v[i].lat);
            end
            n_checks++;
            if (gaps != 0) begin
                n_fail++;
                $display("FAIL %s[%0d] stall_gaps: got %0d expected 0", tag, i, gaps);
            end
            n_checks++;
            if (xd !== 1'b0) begin
                n_fail++;
                $display("FAIL %s[%0d] done_pulse_width: got %b expected 0", tag, i, xd);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        n_checks++;
        if ({stall, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got stall/busy/done %b expected 000", {stall, busy, done});
        end
        n_checks++;
        if (result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_result: got %h expected 00000000", result);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_mul_timing;
        int bad = 0;
        start = 1'b1; op = 3'd0; rs1 = 32'd7; rs2 = 32'd6;
        #1;
        n_checks++;
        if ({stall, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL mul_cycle0: got stall/busy/done %b expected 100", {stall, busy, done});
        end
        for (int c = 1; c <= 32; c++) begin
            tick;
            if (c == 5) begin
                // operands change mid-run; must be ignored
                rs1 = 32'hDEAD_BEEF; rs2 = 32'd9; op = 3'd5;
            end
            if (stall !== 1'b1 || busy !== 1'b1 || done !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL mul_run_cycles: got %0d bad cycles in 1..32 expected 0", bad);
        end
        tick;
        n_checks++;
        if ({stall, busy, done} !== 3'b011) begin
            n_fail++;
            $display("FAIL mul_done_cycle33: got stall/busy/done %b expected 011", {stall, busy, done});
        end
        n_checks++;
        if (result !== 32'd42) begin
            n_fail++;
            $display("FAIL mul_7x6: got %h expected 0000002a", result);
        end
        start = 1'b0;
        tick;
        n_checks++;
        if ({stall, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL mul_after_done: got stall/busy/done %b expected 000", {stall, busy, done});
        end
    endtask

    task automatic test_mul_variants;
        vec_t v[] = new[8];
        v[0] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        v[1] = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        v[2] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        v[3] = '{3'd0, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 33};
        v[4] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 33};
        v[5] = '{3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 33};
        v[6] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
        v[7] = '{3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33};
        run_table("mul", v);
    endtask

    task automatic test_div;
        vec_t v[] = new[8];
        v[0] = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
        v[1] = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
        v[2] = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
        v[3] = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
        v[4] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        v[5] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         33};
        v[6] = '{3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
        v[7] = '{3'd7, 32'd7,         32'd100,       32'd7,         33};
        run_table("div", v);
    endtask

    task automatic test_special;
        vec_t v[] = new[7];
        v[0] = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        v[1] = '{3'd6, 32'd5,         32'd0,         32'd5,         1};
        v[2] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        v[3] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        v[4] = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        v[5] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33};
        v[6] = '{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
        run_table("special", v);
    endtask

    task automatic test_reset_mid_run;
        logic        seen_done = 1'b0;
        logic [31:0] res;
        int          lat, gaps;
        logic        xd, to;
        start = 1'b1; op = 3'd0; rs1 = 32'd7; rs2 = 32'd6;
        #1;
        n_checks++;
        if (result !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL rst_mid_result_held: got %h expected 80000000", result);
        end
        repeat (10) tick;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_busy_before: got %b expected 1", busy);
        end
        #2;
        reset = 1'b1;
        start = 1'b0;
        #1;
        n_checks++;
        if ({stall, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid_flags: got stall/busy/done %b expected 000", {stall, busy, done});
        end
        n_checks++;
        if (result !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_result: got %h expected 00000000", result);
        end
        repeat (3) begin
            tick;
            if (done === 1'b1) seen_done = 1'b1;
        end
        reset = 1'b0;
        repeat (2) begin
            tick;
            if (done === 1'b1) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_no_done: got %b expected 0", seen_done);
        end
        do_op(3'd3, 32'h0001_0000, 32'h0003_0000, res, lat, gaps, xd, to);
        n_checks++;
        if (res !== 32'h0000_0003 || to !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_reaccept_result: got %h expected 00000003", res);
        end
        n_checks++;
        if (lat != 33) begin
            n_fail++;
            $display("FAIL rst_mid_reaccept_latency: got %0d expected 33", lat);
        end
    endtask

    task automatic test_back_to_back;
        int          dones = 0;
        int          first_done = -1;
        int          second_done = -1;
        logic [31:0] res1 = 32'd0;
        logic [31:0] res2 = 32'd0;
        logic        held_ok = 1'b1;
        start = 1'b1; op = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
        #1;
        for (int c = 1; c <= 75; c++) begin
            tick;
            if (first_done > 0 && c == first_done + 1) begin
                // pipeline advanced on the done cycle: next instruction here
                op = 3'd4; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2;
            end
            if (first_done > 0 && second_done < 0 && done !== 1'b1 &&
                result !== 32'd14) held_ok = 1'b0;
            if (done === 1'b1) begin
                dones++;
                if (first_done < 0) begin
                    first_done = c;
                    res1 = result;
                end else if (second_done < 0) begin
                    second_done = c;
                    res2 = result;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        n_checks++;
        if (first_done != 33) begin
            n_fail++;
            $display("FAIL b2b_first_done_cycle: got %0d expected 33", first_done);
        end
        n_checks++;
        if (res1 !== 32'd14) begin
            n_fail++;
            $display("FAIL b2b_first_result: got %h expected 0000000e", res1);
        end
        n_checks++;
        if (held_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_result_held: got %b expected 1", held_ok);
        end
        n_checks++;
        if (second_done != 67) begin
            n_fail++;
            $display("FAIL b2b_second_done_cycle: got %0d expected 67", second_done);
        end
        n_checks++;
        if (res2 !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL b2b_second_result: got %h expected fffffffd", res2);
        end
        n_checks++;
        if (dones != 2) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d expected 2", dones);
        end
    endtask

    initial begin
        test_reset;
        test_mul_timing;
        test_mul_variants;
        test_div;
        test_special;
        test_reset_mid_run;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
